// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: registered immediate extender (zero/sign/upper/branch) with valid/ready handshake.
// Ports: CLK clock; RST sync active-low reset; in_valid/in_ready/in_imm/in_mode accept side;
//        out_valid/out_ready/out_data result side; occupancy = results held (0-2).
// Optional feature: define EXT_SKID_EN to add a skid register and make in_ready a pure flop output.
module ext_unit_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       occupancy
);
    logic [OUT_W-1:0] zx, sx, ext_data, main_data;
    logic main_valid, skid_valid, accept, xfer;
    always_comb begin
        zx = OUT_W'(in_imm);
        sx = OUT_W'($signed(in_imm));
        ext_data = in_mode == 2'b00 ? zx :
                   in_mode == 2'b01 ? sx :
                   in_mode == 2'b10 ? zx << (OUT_W - IN_W) : sx << SHAMT;
    end
    assign accept    = in_valid & in_ready;
    assign xfer      = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
`ifdef EXT_SKID_EN
    logic [OUT_W-1:0] skid_data;
    // skid_valid is a flop, so in_ready carries no combinational path from out_ready
    assign in_ready = !skid_valid;
    always_ff @(posedge CLK)
        if (!RST) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (xfer) begin
            // accept is impossible while the skid is full, so the skid never needs refilling here
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept)
                main_data <= ext_data;
            else
                main_valid <= 1'b0;
        end else if (accept) begin
            if (main_valid) begin
                skid_data  <= ext_data;
                skid_valid <= 1'b1;
            end else begin
                main_data  <= ext_data;
                main_valid <= 1'b1;
            end
        end
`else
    assign skid_valid = 1'b0;
    assign in_ready   = !main_valid | out_ready;
    always_ff @(posedge CLK)
        if (!RST) begin
            main_valid <= 1'b0;
            main_data  <= '0;
        end else if (accept) begin
            main_data  <= ext_data;
            main_valid <= 1'b1;
        end else if (xfer)
            main_valid <= 1'b0;
`endif
endmodule

// File: tb/tb_ext_unit_pipe.sv
// tb_ext_unit_pipe: directed and random checks of ext_unit_pipe at IN_W=16, OUT_W=32, SHAMT=2.
module tb_ext_unit_pipe;
    logic        CLK = 0, RST = 0, in_valid = 0, out_ready = 1;
    logic        in_ready, out_valid;
    logic [15:0] in_imm = 0;
    logic [1:0]  in_mode = 0;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    int checks = 0, errors = 0;

    ext_unit_pipe dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] s;
        s = {{16{imm[15]}}, imm};
        case (mode)
            2'd0: return {16'h0000, imm};
            2'd1: return s;
            2'd2: return {imm, 16'h0000};
            default: return {s[29:0], 2'b00};
        endcase
    endfunction

    task automatic test_reset;
        RST = 0; in_valid = 1; in_imm = 16'h1234; in_mode = 2'd1; out_ready = 0;
        step; step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        RST = 1; in_valid = 0; out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_result: got %b expected 0", out_valid); end
    endtask

    task automatic test_modes;
        logic [15:0] imms [6] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'hFFFF, 16'h7FFF};
        logic [1:0]  modes[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [31:0] exps [6] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004,
                                  32'hFFFFFFFC, 32'h0001FFFC};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_imm = imms[i]; in_mode = modes[i];
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode%0d_early_valid: got %b expected 0", i, out_valid); end
            step;
            in_valid = 0; in_mode = ~modes[i]; in_imm = ~imms[i];
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL mode%0d_data: got %h expected %h", i, out_data, exps[i]); end
            step;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode%0d_drain: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure;
        out_ready = 0; in_valid = 1; in_mode = 2'd0; in_imm = 16'd1;
        step;
        in_imm = 16'd2;
        #1;
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1: got %0d expected 1", occupancy); end
`ifdef EXT_SKID_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", in_ready); end
        step;
        in_imm = 16'd3;
        #1;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2: got %0d expected 2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2: got %b expected 0", in_ready); end
        step;
        checks++; if (occupancy !== 2'd2 || out_data !== 32'd1) begin errors++; $display("FAIL bp_hold: got occ %0d data %h expected occ 2 data 00000001", occupancy, out_data); end
        out_ready = 1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 32'(k)) begin errors++; $display("FAIL bp_order%0d: got valid %b data %h expected valid 1 data %h", k, out_valid, out_data, 32'(k)); end
            step;
            if (k == 2) in_valid = 0;
        end
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready1: got %b expected 0", in_ready); end
        step;
        in_imm = 16'd3;
        #1;
        checks++; if (occupancy !== 2'd1 || out_data !== 32'd1) begin errors++; $display("FAIL bp_hold: got occ %0d data %h expected occ 1 data 00000001", occupancy, out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2: got %b expected 0", in_ready); end
        in_imm = 16'd2;
        out_ready = 1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 32'(k) || in_ready !== 1'b1) begin errors++; $display("FAIL bp_order%0d: got valid %b data %h ready %b expected 1 %h 1", k, out_valid, out_data, in_ready, 32'(k)); end
            step;
            in_imm = 16'd3;
            if (k == 2) in_valid = 0;
        end
`endif
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 0; in_valid = 1; in_mode = 2'd1; in_imm = 16'hAAAA;
        step; step;
        in_valid = 0;
        #1;
`ifdef EXT_SKID_EN
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rm_occ_before: got %0d expected 2", occupancy); end
`else
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL rm_occ_before: got %0d expected 1", occupancy); end
`endif
        RST = 0;
        step;
        RST = 1; out_ready = 1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rm_cleared: got valid %b data %h occ %0d ready %b expected 0 00000000 0 1", out_valid, out_data, occupancy, in_ready); end
        for (int k = 0; k < 3; k++) begin
            step;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale%0d: got %b expected 0", k, out_valid); end
        end
    endtask

    task automatic test_random;
        logic [31:0] q[$];
        logic        prev_stall = 0;
        logic [31:0] prev_data = 0;
        logic [31:0] exp_d;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            #1;
            checks++; if (occupancy !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ@%0d: got %0d expected %0d", c, occupancy, q.size()); end
`ifdef EXT_SKID_EN
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, in_ready, q.size() < 2); end
`else
            checks++; if (in_ready !== (q.size() == 0 || out_ready)) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, in_ready, q.size() == 0 || out_ready); end
`endif
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin errors++; $display("FAIL rnd_stable@%0d: got valid %b data %h expected 1 %h", c, out_valid, out_data, prev_data); end
            end
            if (out_valid && out_ready) begin
                exp_d = q.size() > 0 ? q[0] : 32'hxxxxxxxx;
                checks++; if (q.size() == 0 || out_data !== exp_d) begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h (queue %0d)", c, out_data, exp_d, q.size()); end
                if (q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(ref_ext(in_imm, in_mode));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step;
        end
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 4 && q.size() > 0; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== q[0]) begin errors++; $display("FAIL rnd_tail: got valid %b data %h expected 1 %h", out_valid, out_data, q[0]); end
            void'(q.pop_front());
            step;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_empty: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset;
        test_modes;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ext_unit_pipe.md
# ext_unit_pipe

Parametrised, registered immediate-extension unit with a valid/ready handshake, replacing the combinational 16→32 extender on the decode→execute path of the pipelined CPU. It widens an IN_W-bit immediate to OUT_W bits in one of four modes (zero, sign, upper-load, branch-offset) and holds results under back-pressure. An optional skid register allows full throughput with a registered in_ready.

## Interface
- IN_W, 16, input immediate width; must be ≥ 2.
- OUT_W, 32, output width; must be ≥ IN_W.
- SHAMT, 2, left shift applied in branch-offset mode; must be in the range 0 to OUT_W−1.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset.
- in_valid  in  1  producer holds in_imm/in_mode valid.
- in_ready  out  1  unit can accept this cycle.
- in_imm  in  IN_W  immediate field.
- in_mode  in  2  00 zero, 01 sign, 10 upper, 11 branch.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  OUT_W  extended result.
- occupancy  out  2  number of results held (0–2).

## Operation
- An accept occurs on a cycle with in_valid & in_ready. A transfer occurs on a cycle with out_valid & out_ready.
- in_imm and in_mode are both captured at accept. A later change to in_mode does not affect results already held.
- Modes, computed at accept with E = OUT_W−IN_W:
  - 00 zero: {E zeros, in_imm}.
  - 01 sign: {E copies of in_imm[IN_W−1], in_imm}.
  - 10 upper: in_imm << E, low E bits zero. When E = 0 this equals zero mode.
  - 11 branch: sign-extended value << SHAMT, truncated to OUT_W bits, low SHAMT bits zero.
- Storage is a main output register plus, with EXT_SKID_EN, one skid register.
- Ordering is strictly FIFO. The skid entry moves to the main register on the cycle the main entry transfers.
- An accept and a transfer in the same cycle:
  - main-only occupied → new result goes to main; occupancy unchanged.
  - main and skid occupied → cannot occur, because in_ready = 0.
- occupancy = main_valid + skid_valid, registered.

## Timing
- Latency is 1 cycle: a result accepted at edge N has out_valid = 1 after edge N, at the earliest.
- Reset (RST = 0 at an edge) clears all state:
  - out_valid = 0, out_data = 0, occupancy = 0.
  - in_ready = 1 from the first cycle after reset.
  - Any in-flight or held result is discarded.
  - Inputs are ignored during reset cycles.
- out_data and out_valid stay stable while out_valid & !out_ready.
- in_ready, with EXT_SKID_EN, is a register equal to !skid_valid. Throughput is one result per cycle under continuous out_ready. One extra result is absorbed on the first stall cycle.
- No combinational path from in_* to out_*.

## Configuration
- EXT_SKID_EN defined:
  - skid register present.
  - in_ready is registered and has no combinational dependence on out_ready.
  - occupancy ranges 0–2.
- EXT_SKID_EN undefined:
  - no skid register.
  - in_ready = !out_valid | out_ready, which is combinational from out_ready.
  - occupancy ranges 0–1.
  - Throughput and latency are otherwise identical; same-cycle accept/transfer is still allowed.

## Test plan
Defaults: IN_W = 16, OUT_W = 32, SHAMT = 2, out_ready = 1 unless stated.
- Mode sweep, with in_imm = 16'h8001 in every mode:
  - zero → 32'h00008001.
  - sign → 32'hFFFF8001.
  - upper → 32'h80010000.
  - branch → 32'hFFFE0004.
  - Each result appears one cycle after accept.
- Branch mode, in_imm = 16'hFFFF → 32'hFFFFFFFC; in_imm = 16'h7FFF → 32'h0001FFFC.
- Back-pressure with EXT_SKID_EN:
  - Stimulus: hold out_ready = 0 while streaming in_imm = 1, 2, 3.
  - Required: occupancy reaches 2, in_ready drops after the second accept, and input 3 is held off.
  - Then release out_ready: results emerge as 1, 2, 3 in order with no gaps.
- Back-pressure without EXT_SKID_EN:
  - Stimulus: the same stream with out_ready = 0.
  - Required: in_ready = 0 while out_valid = 1, and occupancy never exceeds 1.
- Reset mid-operation:
  - Stimulus: occupancy = 2, then RST = 0 for one cycle.
  - Required: out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1 on the next cycle, and no stale result is ever emitted.
- Random valid/ready (10k cycles, random modes): compare against a scoreboard model; require no loss, duplication or reordering, and every held result stays stable while stalled.
